// File: rtl/plat_pkg.sv
// rtl/plat_pkg.sv - shared encodings and constants for the platform scroller
// Optional speedup constants are consumed only when PLAT_SPEEDUP_EN is defined.
package plat_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Each speedup level removes TICK_DIV/SPEEDUP_STEP_DIV clocks from the tick period.
  localparam int SPEEDUP_STEP_DIV  = 8;
  localparam int SPEEDUP_RETIRES   = 8;
  localparam int SPEEDUP_MAX_LEVEL = 4;
  localparam int LEVEL_W           = 3;

  function automatic coord_t coord_add(input coord_t a, input int unsigned b);
    return a + b[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/plat_tick_gen.sv
// rtl/plat_tick_gen.sv - scroll prescaler: counts enabled cycles, flags the wrap cycle
// tick is high during the cycle the count sits at div-1; the count reloads to 0 on that edge.
module plat_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] div,
  output logic        tick
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        at_end;

  always_comb begin
    // >= keeps the counter wrapping even if div shrinks below the current count
    at_end = (cnt_q >= (div - 32'd1));
    tick   = en && !clr && at_end;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_end ? 32'd0 : (cnt_q + 32'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/platform_scroll_ctrl.sv
// rtl/platform_scroll_ctrl.sv - scrolling platform slot manager with run/hold/idle control
// Optional feature: PLAT_SPEEDUP_EN shortens the tick period as platforms retire.
module platform_scroll_ctrl
  import plat_pkg::*;
#(
  parameter int TICK_DIV = 840000,
  parameter int SLOTS    = 4,
  parameter int SPACING  = 120,
  parameter int SCREEN_H = 480,
  parameter int HEIGHT   = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     stop,
  output logic [SLOTS*COORD_W-1:0] plat_start,
  output logic [SLOTS*COORD_W-1:0] plat_end,
  output logic [SLOTS-1:0]         plat_valid,
  output logic                     scroll_tick,
  output logic                     spawn,
  output logic                     spawn_miss,
  output logic [7:0]               retire_cnt,
  output logic [1:0]               state
);

  localparam int               GAP_W    = $clog2(SPACING + 1);
  localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(SPACING);
  localparam int               RET_W    = $clog2(SLOTS + 1);
  localparam coord_t           RETIRE_ROW = COORD_W'(SCREEN_H);

  logic [1:0]                    state_q, state_d;
  logic [SLOTS-1:0][COORD_W-1:0] pos_q, pos_d;
  logic [SLOTS-1:0][COORD_W-1:0] end_w;
  logic [SLOTS-1:0]              valid_q, valid_d;
  logic [GAP_W-1:0]              gap_q, gap_d;
  logic [GAP_W-1:0]              gap_now;
  logic                          scroll_tick_q, scroll_tick_d;
  logic                          spawn_q, spawn_d;
  logic                          spawn_miss_q, spawn_miss_d;
  logic [7:0]                    retire_cnt_q, retire_cnt_d;
  logic [RET_W-1:0]              n_ret;
  logic                          slot_found;
  logic [31:0]                   div;
  logic                          tick;

  plat_tick_gen u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_RUN),
    .clr   (stop),
    .div   (div),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)  state_d = ST_RUN;
      ST_RUN:  if (pause)  state_d = ST_HOLD;
      ST_HOLD: if (!pause) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    if (stop) state_d = ST_IDLE;
  end

  always_comb begin
    pos_d         = pos_q;
    valid_d       = valid_q;
    gap_d         = gap_q;
    gap_now       = gap_q;
    scroll_tick_d = 1'b0;
    spawn_d       = 1'b0;
    spawn_miss_d  = spawn_miss_q;
    retire_cnt_d  = retire_cnt_q;
    n_ret         = '0;
    slot_found    = 1'b0;
    if (stop) begin
      pos_d   = '0;
      valid_d = '0;
      gap_d   = '0;
    end else if (state_q == ST_IDLE && start) begin
      gap_d = GAP_FULL;
    end else if (tick) begin
      scroll_tick_d = 1'b1;
      for (int i = 0; i < SLOTS; i++) begin
        if (valid_q[i]) begin
          if (pos_q[i] < RETIRE_ROW) begin
            pos_d[i] = pos_q[i] + 1'b1;
          end else if (pos_q[i] == RETIRE_ROW) begin
            valid_d[i] = 1'b0;
            n_ret      = n_ret + 1'b1;
          end
        end
      end
      // The current tick counts toward the gap, so spawns land SPACING ticks apart.
      gap_now = (gap_q >= GAP_FULL) ? GAP_FULL : (gap_q + 1'b1);
      if (gap_now >= GAP_FULL) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (!valid_q[i] && !slot_found) begin
            slot_found = 1'b1;
            valid_d[i] = 1'b1;
            pos_d[i]   = '0;
          end
        end
        if (slot_found) begin
          spawn_d = 1'b1;
          gap_d   = '0;
        end else begin
          spawn_miss_d = 1'b1;
          gap_d        = GAP_FULL;
        end
      end else begin
        gap_d = gap_now;
      end
      retire_cnt_d = retire_cnt_q + 8'(n_ret);
    end
  end

`ifdef PLAT_SPEEDUP_EN
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [3:0]         spd_cnt_q, spd_cnt_d;
  logic [7:0]         spd_sum;

  always_comb begin
    level_d   = level_q;
    spd_cnt_d = spd_cnt_q;
    spd_sum   = 8'(spd_cnt_q) + 8'(n_ret);
    if (stop) begin
      level_d   = '0;
      spd_cnt_d = '0;
    end else if (spd_sum >= 8'(SPEEDUP_RETIRES)) begin
      spd_cnt_d = 4'(spd_sum - 8'(SPEEDUP_RETIRES));
      if (level_q < LEVEL_W'(SPEEDUP_MAX_LEVEL)) level_d = level_q + 1'b1;
    end else begin
      spd_cnt_d = 4'(spd_sum);
    end
    div = 32'(TICK_DIV) - 32'(level_q) * 32'(TICK_DIV / SPEEDUP_STEP_DIV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      spd_cnt_q <= '0;
    end else begin
      level_q   <= level_d;
      spd_cnt_q <= spd_cnt_d;
    end
  end
`else
  assign div = 32'(TICK_DIV);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pos_q         <= '0;
      valid_q       <= '0;
      gap_q         <= '0;
      scroll_tick_q <= 1'b0;
      spawn_q       <= 1'b0;
      spawn_miss_q  <= 1'b0;
      retire_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      valid_q       <= valid_d;
      gap_q         <= gap_d;
      scroll_tick_q <= scroll_tick_d;
      spawn_q       <= spawn_d;
      spawn_miss_q  <= spawn_miss_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      end_w[i] = coord_add(pos_q[i], HEIGHT);
    end
  end

  assign plat_start  = pos_q;
  assign plat_end    = end_w;
  assign plat_valid  = valid_q;
  assign scroll_tick = scroll_tick_q;
  assign spawn       = spawn_q;
  assign spawn_miss  = spawn_miss_q;
  assign retire_cnt  = retire_cnt_q;
  assign state       = state_q;

endmodule

// File: doc/platform_scroll_ctrl.md
PLATFORM_SCROLL_CTRL -- requirements
Module: platform_scroll_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 840000: clk cycles per scroll tick.
REQ-002 SHALL have parameter SLOTS, default 4: number of platform slots.
REQ-003 SHALL have parameter SPACING, default 120: scroll ticks between spawns.
REQ-004 SHALL have parameter SCREEN_H, default 480: retire row.
REQ-005 SHALL have parameter HEIGHT, default 30: platform thickness in rows.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1: one-cycle pulse; IDLE->RUN.
REQ-009 SHALL have port pause, input, 1: level; RUN<->HOLD.
REQ-010 SHALL have port stop, input, 1: one-cycle pulse; any state->IDLE.
REQ-011 SHALL have port plat_start, output, SLOTS*10: slot i top row at bits [10i+9:10i].
REQ-012 SHALL have port plat_end, output, SLOTS*10: per-slot plat_start+HEIGHT, combinational, mod 1024.
REQ-013 SHALL have port plat_valid, output, SLOTS: slot occupied.
REQ-014 SHALL have port scroll_tick, output, 1: one-cycle pulse per scroll step.
REQ-015 SHALL have port spawn, output, 1: one-cycle pulse when a slot is filled.
REQ-016 SHALL have port spawn_miss, output, 1: sticky; spawn was due with no free slot.
REQ-017 SHALL have port retire_cnt, output, 8: retired platforms, wraps 255->0.
REQ-018 SHALL have port state, output, 2: IDLE=0, RUN=1, HOLD=2.

Function
REQ-019 SHALL use states IDLE, RUN, HOLD; IDLE->RUN on start; RUN->HOLD on pause=1; HOLD->RUN on pause=0; stop wins over every other event.
REQ-020 SHALL count prescaler only in RUN; scroll_tick asserts the cycle the count reaches the divisor minus 1; the count then reloads to 0.
REQ-021 SHALL freeze prescaler, slots and gap counter in HOLD; resuming continues the count from where it stopped.
REQ-022 SHALL, on each tick, increment every valid slot whose plat_start < SCREEN_H.
REQ-023 SHALL, on each tick, clear valid for any slot with plat_start == SCREEN_H and increment retire_cnt once per slot retired.
REQ-024 SHALL load the gap counter to SPACING on entering RUN from IDLE so that the first tick spawns.
REQ-025 SHALL, on a tick with gap >= SPACING, place a platform at plat_start=0 in the lowest-index slot that was free before that tick, pulse spawn, and clear gap.
REQ-026 SHALL not refill a slot retired on the same tick.
REQ-027 SHALL, when no free slot exists, hold gap at SPACING, set spawn_miss, and retry on the next tick.
REQ-028 SHALL otherwise increment gap by 1 per tick, saturating at SPACING.
REQ-029 SHALL, on stop, clear all valid, slots, prescaler and gap within 1 cycle; retire_cnt and spawn_miss keep their values.

Reset
REQ-030 SHALL, with rst_n=0, immediately force state=IDLE, plat_start=0, plat_valid=0, scroll_tick=0, spawn=0, spawn_miss=0, retire_cnt=0, prescaler=0, gap=0.
REQ-031 SHALL, on reset mid-tick, discard any pending spawn or retire.

Configuration
REQ-032 SHALL support macro PLAT_SPEEDUP_EN: when defined, the divisor = TICK_DIV - level*(TICK_DIV/8); level increments every 8 retires, saturates at 4, and clears on stop or reset.
REQ-033 SHALL, without PLAT_SPEEDUP_EN, use a constant divisor of TICK_DIV and contain no level logic.

Structure
REQ-034 SHALL place the state encodings, the 10-bit coordinate width and the speedup step and limit in shared package plat_pkg.
REQ-035 SHALL implement the prescaler as sub-module plat_tick_gen (inputs en, clr, div; output tick).

Verification (TICK_DIV=4, SLOTS=2, SPACING=3, SCREEN_H=10, HEIGHT=3)
REQ-036 SHALL cover: start -> first scroll_tick 4 cycles later, with spawn and slot0 valid at 0 and plat_end=3.
REQ-037 SHALL cover: run for 3 further ticks -> slot1 spawns at 0 while slot0=3.
REQ-038 SHALL cover: both slots full when a spawn is due -> spawn_miss=1 and no spawn until slot0 retires, at its 11th tick, without same-tick refill.
REQ-039 SHALL cover: pause for 20 cycles mid-count -> positions are unchanged and the tick phase resumes exactly.
REQ-040 SHALL cover: rst_n low asserted between clock edges -> all outputs read 0 at once; stop -> plat_valid=0 next cycle and retire_cnt is kept.
REQ-041 SHALL cover, with PLAT_SPEEDUP_EN and TICK_DIV=16: 8 retires -> tick period becomes 14.
